// File: rtl/pipeline_pkg.sv
// Shared fetch-path constants and the {pc, instr} entry type.
package pipeline_pkg;

    localparam int unsigned PC_STEP   = 4;
    localparam logic [31:0] NOP_INSTR = 32'h0;
    localparam int unsigned FE_ADDR_W = 9;
    localparam int unsigned FE_DATA_W = 32;

    typedef struct packed {
        logic [FE_ADDR_W-1:0] pc;
        logic [FE_DATA_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous read port.
module fetch_queue_mem #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 41,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [PTR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [PTR_W-1:0] raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    // Contents are don't-care after reset, so the array carries no reset.
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_fetch_queue.sv
// Prefetch queue owning the fetch PC; buffers {pc, instr} pairs ahead of IF/ID and
// flushes on redirect, optionally keeping one delay-slot entry.
module instr_fetch_queue
    import pipeline_pkg::*;
#(
    parameter int unsigned      DEPTH    = 4,
    parameter int unsigned      ADDR_W   = 9,
    parameter int unsigned      DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    localparam int unsigned     CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_data,
    input  logic              pop,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              redirect_keep,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_instr,
    output logic [ADDR_W-1:0] out_pc,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned ENT_W = ADDR_W + DATA_W;

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, rd_adv;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_pop, do_push;
    logic [ENT_W-1:0]  rd_entry;

    always_comb begin
        do_pop     = pop & (count_q != '0);
        rd_adv     = rd_ptr_q + PTR_W'(do_pop);
        do_push    = 1'b0;
        fetch_pc_d = fetch_pc_q;
        rd_ptr_d   = rd_adv;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        if (redirect) begin
            fetch_pc_d = {redirect_pc[ADDR_W-1:2], 2'b00};
            if (!redirect_keep) begin
                wr_ptr_d = rd_adv;
                count_d  = '0;
            end else if (count_q != CNT_W'(do_pop)) begin
                // Oldest surviving entry becomes the delay slot; drop everything behind it.
                wr_ptr_d = rd_adv + PTR_W'(1);
                count_d  = CNT_W'(1);
            end else begin
                // Nothing left to keep: the instruction at the current PC is the delay slot.
                do_push  = 1'b1;
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
                count_d  = CNT_W'(1);
            end
        end else begin
            do_push = fetch_en & ((count_q != CNT_W'(DEPTH)) | do_pop);
            if (do_push) begin
                wr_ptr_d   = wr_ptr_q + PTR_W'(1);
                fetch_pc_d = fetch_pc_q + ADDR_W'(PC_STEP);
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    fetch_queue_mem #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_mem (
        .clk_i   (clk),
        .we_i    (do_push),
        .waddr_i (wr_ptr_q),
        .wdata_i ({fetch_pc_q, imem_data}),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_entry)
    );

    assign imem_addr = fetch_pc_q;
    assign count     = count_q;
    assign empty     = (count_q == '0);
    assign full      = (count_q == CNT_W'(DEPTH));
    assign out_valid = !empty;
    assign out_instr = empty ? DATA_W'(NOP_INSTR) : rd_entry[DATA_W-1:0];
    assign out_pc    = empty ? '0 : rd_entry[ENT_W-1:DATA_W];

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Randomized and directed bench for instr_fetch_queue against a queue-based reference model.
module tb_instr_fetch_queue;
    import pipeline_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_en, pop, redirect, redirect_keep;
    logic [8:0]  redirect_pc;
    logic [8:0]  imem_addr;
    logic [31:0] imem_data;
    logic        out_valid, full, empty;
    logic [31:0] out_instr;
    logic [8:0]  out_pc;
    logic [2:0]  count;

    logic [31:0]  imem [128];
    fetch_entry_t mq[$];
    logic [8:0]   mpc;
    int           n_checks = 0;
    int           n_fail   = 0;

    always #5 clk = ~clk;

    assign imem_data = imem[imem_addr[8:2]];

    instr_fetch_queue #(
        .DEPTH    (DEPTH),
        .ADDR_W   (9),
        .DATA_W   (32),
        .RESET_PC (9'h000)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .fetch_en      (fetch_en),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .pop           (pop),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .redirect_keep (redirect_keep),
        .out_valid     (out_valid),
        .out_instr     (out_instr),
        .out_pc        (out_pc),
        .count         (count),
        .full          (full),
        .empty         (empty)
    );

    task automatic check_eq(input string tag, input longint unsigned got,
                            input longint unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_model();
        int n;
        n = mq.size();
        check_eq("count", count, n);
        check_eq("out_valid", out_valid, n != 0);
        check_eq("out_pc", out_pc, (n != 0) ? mq[0].pc : 9'h0);
        check_eq("out_instr", out_instr, (n != 0) ? mq[0].instr : 32'h0);
        check_eq("full", full, n == DEPTH);
        check_eq("empty", empty, n == 0);
        check_eq("imem_addr", imem_addr, mpc);
    endtask

    function automatic void model_edge();
        fetch_entry_t e;
        bit           popped;
        popped = pop && mq.size() > 0;
        if (popped) void'(mq.pop_front());
        e.pc    = mpc;
        e.instr = imem[mpc[8:2]];
        if (redirect) begin
            if (!redirect_keep) mq.delete();
            else if (mq.size() > 0) begin
                while (mq.size() > 1) void'(mq.pop_back());
            end else mq.push_back(e);
            mpc = redirect_pc & 9'h1FC;
        end else if (fetch_en && mq.size() < DEPTH) begin
            mq.push_back(e);
            mpc = mpc + 9'd4;
        end
    endfunction

    task automatic step(input logic fe, input logic pp, input logic rd,
                        input logic [8:0] rpc, input logic kp);
        fetch_en      = fe;
        pop           = pp;
        redirect      = rd;
        redirect_pc   = rpc;
        redirect_keep = kp;
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    // Asserts reset mid-cycle and checks the immediate (asynchronous) effect.
    task automatic mid_reset();
        #3;
        reset = 1'b0;
        #1;
        mq.delete();
        mpc = 9'h000;
        check_eq("rst_count", count, 0);
        check_eq("rst_empty", empty, 1);
        check_eq("rst_instr", out_instr, 0);
        check_model();
        #2;
        reset = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 128; i++) imem[i] = $urandom();
        reset = 1'b0;
        fetch_en = 0; pop = 0; redirect = 0; redirect_pc = '0; redirect_keep = 0;
        mpc = 9'h000;
        repeat (2) @(posedge clk);
        #1;
        check_model();
        @(negedge clk);
        reset = 1'b1;

        // Fill to DEPTH, hold when full, then steady push+pop.
        repeat (6) step(1, 0, 0, 9'h0, 0);
        check_eq("full_hold_addr", imem_addr, 9'h010);
        repeat (4) step(1, 1, 0, 9'h0, 0);
        check_eq("stream_count", count, 4);

        // Asynchronous reset with three entries resident.
        step(0, 0, 1, 9'h000, 0);
        repeat (3) step(1, 0, 0, 9'h0, 0);
        check_eq("pre_rst_count", count, 3);
        mid_reset();
        step(0, 0, 0, 9'h0, 0);
        check_eq("post_rst_addr", imem_addr, 9'h000);

        // Flushing redirect, then first fetch from the new PC.
        repeat (2) step(1, 0, 0, 9'h0, 0);
        step(1, 0, 1, 9'h040, 0);
        check_eq("flush_empty", empty, 1);
        step(1, 0, 0, 9'h0, 0);
        check_eq("redir_pc", out_pc, 9'h040);

        // Pop plus keep: second entry survives, PC alignment forced.
        step(0, 0, 1, 9'h008, 0);
        repeat (2) step(1, 0, 0, 9'h0, 0);
        step(0, 1, 1, 9'h081, 1);
        check_eq("keep_pc", out_pc, 9'h00C);
        check_eq("keep_fpc", imem_addr, 9'h080);

        // Empty queue plus keep: delay slot fetched even with fetch_en low.
        step(0, 0, 1, 9'h020, 0);
        step(0, 0, 1, 9'h100, 1);
        check_eq("slot_pc", out_pc, 9'h020);
        check_eq("slot_fpc", imem_addr, 9'h100);

        // Address wrap and pop-on-empty.
        step(0, 0, 1, 9'h1F8, 0);
        repeat (3) step(1, 0, 0, 9'h0, 0);
        check_eq("wrap_addr", imem_addr, 9'h004);
        step(0, 0, 1, 9'h000, 0);
        step(0, 1, 0, 9'h0, 0);
        check_eq("pop_empty", count, 0);

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(199) == 0) mid_reset();
            else step(($urandom_range(3) != 0), $urandom_range(1), ($urandom_range(7) == 0),
                      9'($urandom()), $urandom_range(1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
